// File: rtl/modport_fifo.sv
// rtl/modport_fifo.sv - single-clock 128-bit FIFO with registered read data and status flags
// Optional checks: define MODPORT_FIFO_ASSERT_EN to compile in simulation-only overflow/underflow assertions.
module modport_fifo #(
  parameter int DATA_W        = 128,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = $clog2(DEPTH),
  parameter int ALM_FULL_LVL  = DEPTH - 2,
  parameter int ALM_EMPTY_LVL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty
);

  localparam logic [ADDR_W:0] FULL_CNT      = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ALM_FULL_CNT  = (ADDR_W+1)'(ALM_FULL_LVL);
  localparam logic [ADDR_W:0] ALM_EMPTY_CNT = (ADDR_W+1)'(ALM_EMPTY_LVL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              wr_acc;
  logic              rd_acc;

  // Full gates writes and empty gates reads, so a simultaneous request at either
  // boundary degrades to a single accepted operation.
  assign wr_acc = i_wren && !o_full;
  assign rd_acc = i_rden && !o_empty;

  assign o_full      = (count == FULL_CNT);
  assign o_empty     = (count == '0);
  assign o_alm_full  = (count >= ALM_FULL_CNT);
  assign o_alm_empty = (count <= ALM_EMPTY_CNT);

  // Storage has no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_wrdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      o_rddata <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        o_rddata <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MODPORT_FIFO_ASSERT_EN
  always @(posedge clk) begin
    if (reset) begin
      assert (!(i_wren && o_full)) else $fatal(1, "modport_fifo: write while full");
      assert (!(i_rden && o_empty)) else $fatal(1, "modport_fifo: read while empty");
      assert (count <= FULL_CNT) else $error("modport_fifo: count exceeds depth");
      assert (!(o_full && o_empty)) else $error("modport_fifo: full and empty together");
    end
  end
`else
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// tb/tb_modport_fifo.sv - scoreboard bench for modport_fifo
module tb_modport_fifo;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_wren;
  logic [DATA_W-1:0] i_wrdata;
  logic              i_rden;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full;
  logic              o_empty;
  logic              o_alm_full;
  logic              o_alm_empty;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb [$];
  logic [DATA_W-1:0] exp_rd;
  int                mcount;

  modport_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .i_wren     (i_wren),
    .i_wrdata   (i_wrdata),
    .i_rden     (i_rden),
    .o_rddata   (o_rddata),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_alm_full (o_alm_full),
    .o_alm_empty(o_alm_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ":rddata"}, o_rddata, exp_rd);
    chk({tag, ":full"}, DATA_W'(o_full), DATA_W'(mcount == DEPTH));
    chk({tag, ":empty"}, DATA_W'(o_empty), DATA_W'(mcount == 0));
    chk({tag, ":alm_full"}, DATA_W'(o_alm_full), DATA_W'(mcount >= DEPTH - 2));
    chk({tag, ":alm_empty"}, DATA_W'(o_alm_empty), DATA_W'(mcount <= 2));
  endtask

  // One clock of stimulus; the scoreboard decides acceptance from its own occupancy.
  task automatic step(input string tag, input logic wr, input logic [DATA_W-1:0] d, input logic rd);
    bit wa;
    bit ra;
    @(negedge clk);
    i_wren   = wr;
    i_wrdata = d;
    i_rden   = rd;
    wa = wr && (mcount != DEPTH);
    ra = rd && (mcount != 0);
    if (ra) exp_rd = sb.pop_front();
    if (wa) sb.push_back(d);
    mcount = mcount + int'(wa) - int'(ra);
    @(posedge clk);
    #1;
    chk_all(tag);
    i_wren = 1'b0;
    i_rden = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset    = 1'b0;
    i_wren   = 1'b0;
    i_wrdata = '0;
    i_rden   = 1'b0;
    mcount   = 0;
    exp_rd   = '0;
    #1;
    chk_all("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, DATA_W'(i), 1'b0);
    step("overflow", 1'b1, DATA_W'(32'hDEAD), 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1);
    step("underflow", 1'b0, '0, 1'b1);
    step("underflow2", 1'b0, '0, 1'b1);

    step("simul_empty", 1'b1, DATA_W'(32'h5555), 1'b1);
    step("simul_empty_rd", 1'b0, '0, 1'b1);

    for (int i = 0; i < DEPTH; i++) step("refill", 1'b1, rnd128(), 1'b0);
    step("simul_full", 1'b1, DATA_W'(32'hBEEF), 1'b1);
    for (int i = 0; i < 7; i++) step("to8", 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step("simul_8", 1'b1, rnd128(), 1'b1);
    for (int i = 0; i < 3; i++) step("to5", 1'b0, '0, 1'b1);

    @(negedge clk);
    #2;
    reset = 1'b0;
    sb.delete();
    mcount = 0;
    exp_rd = '0;
    #1;
    chk_all("midreset");
    @(negedge clk);
    reset = 1'b1;
    step("post_reset_wr", 1'b1, DATA_W'(128'hCAFE_F00D_0123_4567_89AB_CDEF_0000_1111), 1'b0);
    step("post_reset_rd", 1'b0, '0, 1'b1);

    for (int i = 0; i < 3; i++) step("wrap_pre", 1'b1, rnd128(), 1'b0);
    for (int i = 0; i < 40; i++) step("wrap", 1'b1, rnd128(), 1'b1);
    for (int i = 0; i < 3; i++) step("wrap_post", 1'b0, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
